// File: rtl/riscv_pkg.sv
// Core-wide shared definitions: data width, memory-port arbiter types and
// LSU access-size encodings.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_WAIT_RSP
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IFU,
        OWN_LSU
    } arb_owner_e;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-enable and store-lane formatter.
// Turns a right-aligned store/load request (size + low address bits) into
// the byte enables and lane-replicated write data seen by a word-wide
// memory port.
//   size       in   access size (SIZE_B / SIZE_H / SIZE_W)
//   adr_lo     in   address bits [1:0]
//   wdata      in   right-aligned store data
//   be         out  byte enables
//   wdata_lane out  store data replicated across every lane
module mem_lane_fmt
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]        size,
    input  logic [1:0]        adr_lo,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_lane
);

    localparam int BE_W = XLEN / 8;

    // Data is replicated into every lane so the byte enables alone select
    // which copy the memory actually writes.
    always_comb begin
        be         = '0;
        wdata_lane = wdata;
        case (size)
            SIZE_B: begin
                be         = BE_W'(1) << adr_lo;
                wdata_lane = {(XLEN/8){wdata[7:0]}};
            end
            SIZE_H: begin
                be         = BE_W'(3) << adr_lo;
                wdata_lane = {(XLEN/16){wdata[15:0]}};
            end
            SIZE_W: begin
                be         = '1;
            end
            default: begin
                be         = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Core memory-port arbiter shared by instruction fetch (IFU) and the
// load/store unit (LSU). LSU has fixed priority, except that after
// STARVE_LIMIT consecutive LSU grants with a fetch waiting, the fetch wins.
// One transaction is outstanding at a time; the response is routed to its
// owner in the same cycle. Fetch responses in flight across a pipeline flush
// are squashed.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ARB_IDLE     | nothing outstanding, free to issue
// ARB_WAIT_RSP | one access granted, waiting for mem_rvalid_i; may issue
//              | the next access in the cycle the response arrives
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   flush_i                    pipeline flush
//   ifu_req_i/adr_i            fetch request and address
//   ifu_gnt_o/rvalid_o/rdata_o/err_o   fetch grant and response
//   lsu_req_i/adr_i/we_i/size_i/wdata_i  LSU request
//   lsu_gnt_o/rvalid_o/rdata_o/err_o   LSU grant and response
//   mem_req_o/adr_o/we_o/be_o/wdata_o  memory request
//   mem_gnt_i/rvalid_i/rdata_i/err_i   memory handshake and response
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,

    input  logic              ifu_req_i,
    input  logic [XLEN-1:0]   ifu_adr_i,
    output logic              ifu_gnt_o,
    output logic              ifu_rvalid_o,
    output logic [XLEN-1:0]   ifu_rdata_o,
    output logic              ifu_err_o,

    input  logic              lsu_req_i,
    input  logic [XLEN-1:0]   lsu_adr_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              lsu_err_o,

    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_err_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [SW-1:0]     streak_q, streak_d;

    logic              can_issue;
    logic              ifu_eff;
    logic              starved;
    logic              sel_lsu;
    logic              sel_ifu;
    logic              gnt;
    logic              rsp;

    logic [XLEN/8-1:0] lsu_be;
    logic [XLEN-1:0]   lsu_wdata_lane;

    // Fetch address is always word aligned; the low bits carry no meaning.
    logic              ifu_adr_unused;
    assign ifu_adr_unused = ^ifu_adr_i[1:0];

    mem_lane_fmt #(
        .XLEN (XLEN)
    ) u_lane_fmt (
        .size       (lsu_size_i),
        .adr_lo     (lsu_adr_i[1:0]),
        .wdata      (lsu_wdata_i),
        .be         (lsu_be),
        .wdata_lane (lsu_wdata_lane)
    );

    assign rsp       = (state_q == ARB_WAIT_RSP) & mem_rvalid_i;
    assign can_issue = (state_q == ARB_IDLE) | rsp;
    assign ifu_eff   = ifu_req_i & ~flush_i;
    assign starved   = ifu_eff & (streak_q == SW'(STARVE_LIMIT));
    assign sel_lsu   = lsu_req_i & ~starved;
    assign sel_ifu   = ~sel_lsu & ifu_eff;

    // Gated by reset_n so every output is quiet while reset is held, even
    // with requesters still asserting.
    assign mem_req_o = reset_n & can_issue & (sel_lsu | sel_ifu);
    assign gnt       = mem_req_o & mem_gnt_i;
    assign lsu_gnt_o = gnt & sel_lsu;
    assign ifu_gnt_o = gnt & sel_ifu;

    always_comb begin
        mem_adr_o   = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel_lsu) begin
                mem_adr_o   = {lsu_adr_i[XLEN-1:2], 2'b00};
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be;
                mem_wdata_o = lsu_wdata_lane;
            end else begin
                mem_adr_o   = {ifu_adr_i[XLEN-1:2], 2'b00};
                mem_be_o    = '1;
            end
        end
    end

    // Response routing: owner sees the memory response in the same cycle.
    // A fetch response is squashed if a flush happened while it was in
    // flight or coincides with it.
    assign lsu_rvalid_o = rsp & (owner_q == OWN_LSU);
    assign ifu_rvalid_o = rsp & (owner_q == OWN_IFU) & ~drop_q & ~flush_i;
    assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
    assign lsu_err_o    = lsu_rvalid_o & mem_err_i;
    assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
    assign ifu_err_o    = ifu_rvalid_o & mem_err_i;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        streak_d = streak_q;

        if (can_issue) begin
            state_d = gnt ? ARB_WAIT_RSP : ARB_IDLE;
        end

        if (gnt) begin
            owner_d = sel_lsu ? OWN_LSU : OWN_IFU;
            drop_d  = 1'b0;
        end else if (flush_i && (state_q == ARB_WAIT_RSP) && (owner_q == OWN_IFU)) begin
            drop_d  = 1'b1;
        end

        if (!ifu_eff || ifu_gnt_o) begin
            streak_d = '0;
        end else if (lsu_gnt_o && (streak_q != SW'(STARVE_LIMIT))) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IFU;
            drop_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            streak_q <= streak_d;
        end
    end

    // A response with nothing outstanding is dropped by the logic above;
    // flag it so the offending memory model gets noticed.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!((state_q == ARB_IDLE) && mem_rvalid_i))
                else $warning("mem_rvalid_i seen with no outstanding transaction");
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IFU) and the execute-stage load/store unit (LSU).
- Arbitrates requests with fixed LSU priority plus an IFU anti-starvation guard. Tracks one outstanding transaction and routes each response to its owner.
- Builds byte enables and lane-aligned store data from the access size.
- Squashes in-flight fetch responses on a pipeline flush.

Parameters:
- XLEN, 32, data/address width; taken from riscv_pkg.
- STARVE_LIMIT, 4, number of consecutive LSU grants while IFU is waiting, after which IFU wins the next arbitration.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (branch/exception)
- ifu_req_i  in  1  fetch request, held until granted
- ifu_adr_i  in  XLEN  fetch address
- ifu_gnt_o  out  1  fetch request accepted this cycle
- ifu_rvalid_o  out  1  fetch data valid
- ifu_rdata_o  out  XLEN  fetch data
- ifu_err_o  out  1  fetch access fault, valid with ifu_rvalid_o
- lsu_req_i  in  1  LSU request (driven from adr_v), held until granted
- lsu_adr_i  in  XLEN  LSU address
- lsu_we_i  in  1  1 = store
- lsu_size_i  in  3  access size: 3'b001 byte, 3'b010 half, 3'b100 word
- lsu_wdata_i  in  XLEN  store data, right-aligned
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rvalid_o  out  1  LSU response valid (load data or store ack)
- lsu_rdata_o  out  XLEN  raw load word (unshifted)
- lsu_err_o  out  1  LSU access fault, valid with lsu_rvalid_o
- mem_req_o  out  1  memory request
- mem_adr_o  out  XLEN  word-aligned address ({adr[XLEN-1:2],2'b00})
- mem_we_o  out  1  write enable
- mem_be_o  out  XLEN/8  byte enables
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  response valid (at least 1 cycle after gnt)
- mem_rdata_i  in  XLEN  response data
- mem_err_i  in  1  response error

Behaviour:
- FSM states: IDLE, WAIT_RSP. Registered owner_q (IFU/LSU), drop_q, streak_q.
- Reset: FSM in IDLE, owner_q=IFU, drop_q=0, streak_q=0. All outputs 0: mem_req_o=0, gnt_o=0, rvalid_o=0, err_o=0.
- Issue window: can_issue = IDLE | (WAIT_RSP & mem_rvalid_i). This gives back-to-back issue, one access per cycle at 1-cycle memory latency.
- ifu_eff = ifu_req_i & ~flush_i. A flushed fetch is never presented to memory.
- Selection when can_issue:
  - If lsu_req_i and not (ifu_eff and streak_q==STARVE_LIMIT), select LSU.
  - Otherwise, if ifu_eff, select IFU.
- mem_req_o = can_issue & (selected requester valid). Address, we, be and wdata are muxed combinationally from the selected requester.
- gnt to the requester = mem_req_o & mem_gnt_i & selected. On gnt: go to WAIT_RSP, owner_q <= selected, drop_q <= 0. No gnt: go to / stay in IDLE.
- streak_q:
  - +1 on LSU gnt while ifu_eff=1, saturating at STARVE_LIMIT.
  - Cleared on IFU gnt, or whenever ifu_eff=0.
- Response: mem_rvalid_i in WAIT_RSP drives owner's rvalid_o/rdata_o/err_o=mem_err_i in the same cycle (combinational, zero-latency routing). Non-owner outputs are 0.
- Flush:
  - flush_i while WAIT_RSP & owner_q=IFU sets drop_q.
  - ifu_rvalid_o = rvalid & owner IFU & ~drop_q & ~flush_i. A flush coincident with the response also squashes it.
  - LSU transactions are never dropped.
- Byte enables:
  - byte: 1 << adr[1:0].
  - half: 4'b0011 << adr[1:0] (adr[1] selects half).
  - word: 4'b1111.
  - Loads use the same be.
  - IFU: be=4'b1111, we=0, wdata=0.
- Store data replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: unchanged.
- Misalignment is checked upstream. The arbiter does not check it.
- mem_rvalid_i in IDLE is a protocol error: ignored, no rvalid_o, flagged by an assertion.
- Reset mid-transaction: state is cleared. A late memory response after reset hits IDLE and is ignored.

Decomposition:
- riscv_pkg additions:
  - typedef enum {ARB_IDLE, ARB_WAIT_RSP}.
  - typedef enum {OWN_IFU, OWN_LSU}.
  - localparams SIZE_B/SIZE_H/SIZE_W (3'b001/3'b010/3'b100).
- Sub-module mem_lane_fmt: combinational be and wdata generation from size/adr/wdata. It is reused later by the data-cache fill path.

Test Plan:
- Idle LSU load: lsu_req, adr 0x104, size W, gnt=1, rvalid next cycle with 0xDEADBEEF. Expect lsu_gnt at t0; lsu_rvalid, rdata 0xDEADBEEF at t1; ifu_rvalid=0.
- Store byte: adr 0x203, wdata 0xA5, size B. Expect mem_adr 0x200, be 4'b1000, wdata 0xA5A5A5A5, we=1. Store half at 0x202, wdata 0x1234: be 4'b1100, wdata 0x12341234.
- Contention/starvation: both requesting continuously, 1-cycle memory. Expect grant sequence LSU×4, IFU, LSU×4, IFU. Expect streak_q reset after each IFU grant.
- Flush in flight: IFU granted at t0, flush_i at t1, rvalid at t2. Expect ifu_rvalid=0 at t2. A flush coincident with rvalid also gives 0. An LSU response under flush is still delivered.
- Back-to-back and error: IFU response cycle overlaps a new LSU grant. Expect both handled with no bubble. mem_err_i=1 on an LSU response gives lsu_err_o=1 and ifu_err_o=0.
- Async reset: assert reset_n=0 in WAIT_RSP. All outputs go to 0 immediately. A later rvalid after release produces no rvalid_o.
